// File: rtl/pd_seq_pkg.sv
// Shared state encoding, registered-output bundle and reset values for the
// power-domain switch/isolation sequencer.
package pd_seq_pkg;

  typedef enum logic [2:0] {
    ST_ON,
    ST_ISO_ON,
    ST_RST_ON,
    ST_SW_OFF,
    ST_OFF,
    ST_SW_ON,
    ST_RST_OFF,
    ST_ISO_OFF
  } state_t;

  typedef struct packed {
    logic iso_n;
    logic pd_rst;
    logic pwr_sw_en;
    logic busy;
    logic pd_off;
  } seq_out_t;

  localparam seq_out_t OUT_RST = '{
    iso_n:     1'b1,
    pd_rst:    1'b0,
    pwr_sw_en: 1'b1,
    busy:      1'b0,
    pd_off:    1'b0
  };

  localparam logic ERR_RST = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Clamp, domain reset and switch levels owned by each sequencing state.
  function automatic seq_out_t state_outputs(input state_t st);
    seq_out_t o;
    o = OUT_RST;
    case (st)
      ST_ON:      o = OUT_RST;
      ST_ISO_ON:  o = '{iso_n: 1'b0, pd_rst: 1'b0, pwr_sw_en: 1'b1, busy: 1'b1, pd_off: 1'b0};
      ST_RST_ON:  o = '{iso_n: 1'b0, pd_rst: 1'b1, pwr_sw_en: 1'b1, busy: 1'b1, pd_off: 1'b0};
      ST_SW_OFF:  o = '{iso_n: 1'b0, pd_rst: 1'b1, pwr_sw_en: 1'b0, busy: 1'b1, pd_off: 1'b0};
      ST_OFF:     o = '{iso_n: 1'b0, pd_rst: 1'b1, pwr_sw_en: 1'b0, busy: 1'b0, pd_off: 1'b1};
      ST_SW_ON:   o = '{iso_n: 1'b0, pd_rst: 1'b1, pwr_sw_en: 1'b1, busy: 1'b1, pd_off: 1'b0};
      ST_RST_OFF: o = '{iso_n: 1'b0, pd_rst: 1'b1, pwr_sw_en: 1'b1, busy: 1'b1, pd_off: 1'b0};
      ST_ISO_OFF: o = '{iso_n: 1'b0, pd_rst: 1'b0, pwr_sw_en: 1'b1, busy: 1'b1, pd_off: 1'b0};
      default:    o = OUT_RST;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pd_seq_dly_cnt.sv
// Loadable saturating down-counter with a zero flag; one instance serves both the
// fixed delays and the ack timeouts of the sequencer.
module pd_seq_dly_cnt #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pd_iso_sequencer.sv
// Power-domain sequencer: orders clamp, domain reset, power switch and ack on
// power-down and power-up, with an ack timeout that recovers to a safe state.
module pd_iso_sequencer
  import pd_seq_pkg::*;
#(
  parameter int ISO_DLY     = 4,
  parameter int RST_DLY     = 4,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pd_down_req,
  input  logic i_pd_up_req,
  input  logic i_pwr_ack,
  output logic o_iso_n,
  output logic o_pd_rst,
  output logic o_pwr_sw_en,
  output logic o_busy,
  output logic o_pd_off,
  output logic o_err
);

  localparam int CNT_W = $clog2(max3(ISO_DLY, RST_DLY, ACK_TIMEOUT) + 1);

  // A wait of N cycles loads N-1: the exit edge is the one that samples zero.
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] ACK_LD = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  seq_out_t         out_q;
  logic             err_q, err_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  pd_seq_dly_cnt #(.W(CNT_W)) u_dly_cnt (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // An arriving ack is tested before the timeout so it wins on the final cycle.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_ON: begin
        if (i_pd_down_req) begin
          state_d      = ST_ISO_ON;
          err_d        = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = ISO_LD;
        end
      end
      ST_ISO_ON: begin
        if (cnt_zero) state_d = ST_RST_ON;
      end
      ST_RST_ON: begin
        state_d      = ST_SW_OFF;
        cnt_load     = 1'b1;
        cnt_load_val = ACK_LD;
      end
      ST_SW_OFF: begin
        if (!i_pwr_ack) begin
          state_d = ST_OFF;
        end else if (cnt_zero) begin
          state_d      = ST_SW_ON;
          err_d        = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = ACK_LD;
        end
      end
      ST_OFF: begin
        if (i_pd_up_req) begin
          state_d      = ST_SW_ON;
          err_d        = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = ACK_LD;
        end
      end
      ST_SW_ON: begin
        if (i_pwr_ack) begin
          state_d      = ST_RST_OFF;
          cnt_load     = 1'b1;
          cnt_load_val = RST_LD;
        end else if (cnt_zero) begin
          state_d = ST_OFF;
          err_d   = 1'b1;
        end
      end
      ST_RST_OFF: begin
        if (cnt_zero) begin
          state_d      = ST_ISO_OFF;
          cnt_load     = 1'b1;
          cnt_load_val = ISO_LD;
        end
      end
      ST_ISO_OFF: begin
        if (cnt_zero) state_d = ST_ON;
      end
      default: state_d = ST_ON;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_ON;
      out_q   <= OUT_RST;
      err_q   <= ERR_RST;
    end else begin
      state_q <= state_d;
      out_q   <= state_outputs(state_d);
      err_q   <= err_d;
    end
  end

  assign o_iso_n     = out_q.iso_n;
  assign o_pd_rst    = out_q.pd_rst;
  assign o_pwr_sw_en = out_q.pwr_sw_en;
  assign o_busy      = out_q.busy;
  assign o_pd_off    = out_q.pd_off;
  assign o_err       = err_q;

endmodule

// File: tb/tb_pd_iso_sequencer.sv
// Self-checking bench for pd_iso_sequencer: directed vector table, timeout corner
// sequences and randomized traffic against a phase/elapsed-time reference model.
module tb_pd_iso_sequencer;

  localparam int ISO_DLY     = 4;
  localparam int RST_DLY     = 4;
  localparam int ACK_TIMEOUT = 256;

  // Bit positions in the packed output view {iso_n, pd_rst, sw_en, busy, pd_off, err}.
  localparam int B_ISO  = 5;
  localparam int B_SW   = 3;
  localparam int B_BUSY = 2;
  localparam int B_OFF  = 1;
  localparam int B_ERR  = 0;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic downReq = 1'b0;
  logic upReq   = 1'b0;
  logic pwrAck  = 1'b1;
  logic isoN, pdRst, swEn, busy, pdOff, err;
  logic [5:0] dutOut;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  pd_iso_sequencer #(
    .ISO_DLY     (ISO_DLY),
    .RST_DLY     (RST_DLY),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .i_clk         (clock),
    .i_rst         (reset),
    .i_pd_down_req (downReq),
    .i_pd_up_req   (upReq),
    .i_pwr_ack     (pwrAck),
    .o_iso_n       (isoN),
    .o_pd_rst      (pdRst),
    .o_pwr_sw_en   (swEn),
    .o_busy        (busy),
    .o_pd_off      (pdOff),
    .o_err         (err)
  );

  assign dutOut = {isoN, pdRst, swEn, busy, pdOff, err};

  // Reference model: named phase plus cycles elapsed in it, advanced once per edge.
  typedef enum {M_ON, M_ISO_ON, M_RST_ON, M_SW_OFF, M_OFF, M_SW_ON, M_RST_OFF, M_ISO_OFF} mode_t;
  mode_t mode    = M_ON;
  int    elapsed = 0;
  logic  mErr    = 1'b0;

  task automatic enter(input mode_t m);
    mode    = m;
    elapsed = 0;
  endtask

  task automatic modelStep();
    if (reset) begin
      enter(M_ON);
      mErr = 1'b0;
    end else begin
      elapsed++;
      case (mode)
        M_ON:      if (downReq) begin mErr = 1'b0; enter(M_ISO_ON); end
        M_ISO_ON:  if (elapsed == ISO_DLY) enter(M_RST_ON);
        M_RST_ON:  enter(M_SW_OFF);
        M_SW_OFF:  if (!pwrAck) enter(M_OFF);
                   else if (elapsed == ACK_TIMEOUT) begin mErr = 1'b1; enter(M_SW_ON); end
        M_OFF:     if (upReq) begin mErr = 1'b0; enter(M_SW_ON); end
        M_SW_ON:   if (pwrAck) enter(M_RST_OFF);
                   else if (elapsed == ACK_TIMEOUT) begin mErr = 1'b1; enter(M_OFF); end
        M_RST_OFF: if (elapsed == RST_DLY) enter(M_ISO_OFF);
        M_ISO_OFF: if (elapsed == ISO_DLY) enter(M_ON);
        default:   enter(M_ON);
      endcase
    end
  endtask

  function automatic logic [5:0] expectedOut();
    logic iso, rstO, sw, bsy, off;
    iso  = (mode == M_ON);
    rstO = !(mode == M_ON || mode == M_ISO_ON || mode == M_ISO_OFF);
    sw   = !(mode == M_SW_OFF || mode == M_OFF);
    bsy  = !(mode == M_ON || mode == M_OFF);
    off  = (mode == M_OFF);
    return {iso, rstO, sw, bsy, off, mErr};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic d, input logic u, input logic a);
    reset   = r;
    downReq = d;
    upReq   = u;
    pwrAck  = a;
  endtask

  // One clock edge: advance the model with the sampled inputs, then compare #1 later.
  task automatic cycle(input string tag);
    @(posedge clock);
    modelStep();
    #1;
    checkOutput({tag, "/model"}, 32'(dutOut), 32'(expectedOut()));
    checkOutput({tag, "/iso_invariant"}, 32'(isoN & (pdRst | ~swEn)), 32'd0);
  endtask

  task automatic waitBit(input int idx, input logic val, input int maxCycles, input string tag,
                         output int n);
    n = 0;
    while (dutOut[idx] !== val && n < maxCycles) begin
      cycle(tag);
      n++;
    end
    if (dutOut[idx] !== val) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s: wait expired after %0d cycles, bit %0d is %b, expected %b",
               tag, n, idx, dutOut[idx], val);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic       down;
    logic       up;
    logic       ack;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[25];
  int   n;
  int   stuck;
  logic rr, rd, ru, ra;

  initial begin
    // Reset, down with simultaneous up, ignored up in ISO_ON, ack falls at 3rd cycle,
    // then power-up with ack rising after 5 cycles.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b101000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b001100};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b001100};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001100};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001100};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011100};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b010100};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b010100};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b010100};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b010010};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b010010};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b011100};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b011100};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b011100};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b011100};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b011100};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011100};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011100};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011100};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011100};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001100};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001100};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001100};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001100};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b101000};

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].down, vecs[i].up, vecs[i].ack);
      cycle("vec");
      checkOutput($sformatf("vec%0d", i), 32'(dutOut), 32'(vecs[i].exp));
    end

    // Power-up with ack stuck low times out back to OFF; the next up request clears err.
    applyStimulus(0, 1, 0, 1);
    cycle("t3_down");
    applyStimulus(0, 0, 0, 1);
    waitBit(B_SW, 1'b0, 20, "t3_reach_swoff", n);
    applyStimulus(0, 0, 0, 0);
    waitBit(B_OFF, 1'b1, 10, "t3_reach_off", n);
    applyStimulus(0, 0, 1, 0);
    cycle("t3_up");
    applyStimulus(0, 0, 0, 0);
    waitBit(B_OFF, 1'b1, ACK_TIMEOUT + 20, "t3_timeout", n);
    checkOutput("t3_timeout_cycles", 32'(n), 32'(ACK_TIMEOUT));
    checkOutput("t3_err_off_state", 32'(dutOut), 32'(6'b010011));
    applyStimulus(0, 0, 1, 0);
    cycle("t3_up_again");
    checkOutput("t3_err_cleared", 32'(err), 32'd0);
    applyStimulus(0, 0, 0, 1);
    waitBit(B_BUSY, 1'b0, 20, "t3_to_on", n);
    checkOutput("t3_back_on", 32'(dutOut), 32'(6'b101000));

    // Power-down with ack stuck high recovers through a power-up to ON, err sticky.
    applyStimulus(0, 1, 0, 1);
    cycle("t4a_down");
    applyStimulus(0, 0, 0, 1);
    waitBit(B_SW, 1'b0, 20, "t4a_reach_swoff", n);
    waitBit(B_SW, 1'b1, ACK_TIMEOUT + 20, "t4a_timeout", n);
    checkOutput("t4a_timeout_cycles", 32'(n), 32'(ACK_TIMEOUT));
    checkOutput("t4a_err_set", 32'(err), 32'd1);
    waitBit(B_BUSY, 1'b0, 20, "t4a_to_on", n);
    checkOutput("t4a_on_err_sticky", 32'(dutOut), 32'(6'b101001));

    // Ack falling on the final timeout cycle wins: clean OFF, err cleared by the request.
    applyStimulus(0, 1, 0, 1);
    cycle("t4b_down");
    applyStimulus(0, 0, 0, 1);
    waitBit(B_SW, 1'b0, 20, "t4b_reach_swoff", n);
    for (int i = 1; i < ACK_TIMEOUT; i++) cycle("t4b_hold");
    applyStimulus(0, 0, 0, 0);
    cycle("t4b_last");
    checkOutput("t4b_ack_wins", 32'(dutOut), 32'(6'b010010));

    // Reset in the middle of RST_OFF aborts straight to reset values.
    applyStimulus(0, 0, 1, 1);
    cycle("t6_up");
    applyStimulus(0, 0, 0, 1);
    cycle("t6_rst_off");
    cycle("t6_rst_off_hold");
    applyStimulus(1, 0, 0, 1);
    cycle("t6_reset");
    checkOutput("t6_reset_values", 32'(dutOut), 32'(6'b101000));
    applyStimulus(0, 0, 0, 1);
    cycle("t6_release");

    // Random traffic: the ack follows the switch with random lag, with occasional stuck windows.
    stuck = 0;
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 599) == 0);
      rd = ($urandom_range(0, 5) == 0);
      ru = ($urandom_range(0, 5) == 0);
      ra = pwrAck;
      if (stuck > 0) stuck--;
      else if ($urandom_range(0, 299) == 0) stuck = $urandom_range(200, 300);
      else if ($urandom_range(0, 2) == 0) ra = swEn;
      applyStimulus(rr, rd, ru, ra);
      cycle("rand");
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
